// File: rtl/coreahblsram_pkg.sv
// Shared encodings for the AHB-Lite SRAM controller slice: HSIZE codes, FSM states
// and the legal window for RAM read latency.
package coreahblsram_pkg;

    localparam logic [2:0] SZ_BYTE = 3'b000;
    localparam logic [2:0] SZ_HALF = 3'b001;
    localparam logic [2:0] SZ_WORD = 3'b010;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // The 2-bit latency counter bounds the read latency to this window.
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

endpackage

// File: rtl/coreahblsram_be_decode.sv
// Byte-enable decode: HSIZE + byte address low bits -> 4 lane enables, purely combinational.
// Unsupported sizes decode to no lanes; no flow control.
module coreahblsram_be_decode
    import coreahblsram_pkg::*;
(
    input  logic [2:0] i_size,
    input  logic [1:0] i_addr_lo,
    output logic [3:0] o_be
);

    always_comb begin
        o_be = 4'b0000;
        case (i_size)
            SZ_BYTE: o_be = 4'b0001 << i_addr_lo;
            SZ_HALF: o_be = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: o_be = 4'b1111;
            default: o_be = 4'b0000;
        endcase
    end

endmodule

// File: rtl/coreahblsram_sram_ctrl.sv
// SRAM-side controller: turns AHB-stage request pulses into LSRAM strobes; write ack 1 cycle
// after req, read ack 2+RD_LATENCY cycles after req. Requests arriving while busy are dropped with err_drop.
module coreahblsram_sram_ctrl
    import coreahblsram_pkg::*;
#(
    parameter int MEM_AWIDTH = 19,
    parameter int RD_LATENCY = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESETN,
    input  logic                  ahbsram_req,
    input  logic                  ahbsram_write,
    input  logic [2:0]            ahbsram_size,
    input  logic [MEM_AWIDTH-1:0] ahbsram_addr,
    input  logic [31:0]           ahbsram_wdata,
    output logic                  sramahb_ack,
    output logic [31:0]           sramahb_rdata,
    output logic [MEM_AWIDTH-3:0] ram_addr,
    output logic                  ram_wen,
    output logic                  ram_ren,
    output logic [3:0]            ram_be,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata,
    output logic                  err_drop
);

    localparam logic [1:0] LAT = RD_LATENCY[1:0];

    logic [1:0]            r_state;
    logic [1:0]            r_cnt;
    logic [MEM_AWIDTH-3:0] r_addr;
    logic [3:0]            r_be;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;

    logic [3:0] w_be;
    logic [3:0] w_be_cap;
    logic       w_idle;
    logic       w_rd_done;

    coreahblsram_be_decode u_be_decode (
        .i_size    (ahbsram_size),
        .i_addr_lo (ahbsram_addr[1:0]),
        .o_be      (w_be)
    );

    // Reads of an unsupported size still fetch the whole word.
    assign w_be_cap  = (!ahbsram_write && (w_be == 4'b0000)) ? 4'b1111 : w_be;
    assign w_idle    = (r_state == ST_IDLE);
    assign w_rd_done = (r_state == ST_READ) && (r_cnt == LAT);

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_addr  <= '0;
            r_be    <= 4'b0000;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ahbsram_req) begin
                        r_state <= ahbsram_write ? ST_WRITE : ST_READ;
                        r_cnt   <= 2'd0;
                        r_addr  <= ahbsram_addr[MEM_AWIDTH-1:2];
                        r_be    <= w_be_cap;
                        r_wdata <= ahbsram_wdata;
                    end
                end
                ST_WRITE: r_state <= ST_IDLE;
                ST_READ: begin
                    // r_cnt counts cycles since the ram_ren cycle; data lands when it reaches LAT.
                    if (w_rd_done) begin
                        r_rdata <= ram_rdata;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign sramahb_ack   = (r_state == ST_WRITE) || (r_state == ST_RESP);
    assign sramahb_rdata = r_rdata;
    assign ram_addr      = r_addr;
    assign ram_be        = r_be;
    assign ram_wdata     = r_wdata;
    assign ram_wen       = (r_state == ST_WRITE) && (r_be != 4'b0000);
    assign ram_ren       = (r_state == ST_READ) && (r_cnt == 2'd0);
    assign err_drop      = ahbsram_req && !w_idle;

endmodule

// File: tb/tb_coreahblsram_sram_ctrl.sv
// Bench for coreahblsram_sram_ctrl: two instances (read latency 1 and 3) share one request
// stream; a transaction-level model schedules expected events into a queue that a monitor checks.
module tb_coreahblsram_sram_ctrl;

    logic        HCLK;
    logic        HRESETN;
    logic        req;
    logic        write;
    logic [2:0]  size;
    logic [18:0] addr;
    logic [31:0] wdata;

    logic        ack_w [2];
    logic        wen_w [2];
    logic        ren_w [2];
    logic        err_w [2];
    logic [31:0] rd_w  [2];
    logic [31:0] rrd_w [2];
    logic [31:0] wd_w  [2];
    logic [16:0] ra_w  [2];
    logic [3:0]  be_w  [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 0;

    typedef struct {
        int          inst;
        int          cyc;
        bit          ack;
        bit          wen;
        bit          ren;
        bit          err;
        bit          bus;
        bit          wr;
        logic [16:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } ev_t;

    ev_t         evq [$];
    int          busy [2];
    logic [31:0] hold [2];
    logic [31:0] ref_mem [int];

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input logic [16:0] w);
        return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int l = 0; l < 4; l++)
            if (be[l]) r[8*l +: 8] = wd[8*l +: 8];
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : 3;
        logic [31:0] mem [int];
        logic [31:0] pipe [3];
        logic [2:0]  pv;
        initial pv = 3'b000;

        coreahblsram_sram_ctrl #(.MEM_AWIDTH(19), .RD_LATENCY(L)) u_dut (
            .HCLK          (HCLK),
            .HRESETN       (HRESETN),
            .ahbsram_req   (req),
            .ahbsram_write (write),
            .ahbsram_size  (size),
            .ahbsram_addr  (addr),
            .ahbsram_wdata (wdata),
            .sramahb_ack   (ack_w[g]),
            .sramahb_rdata (rd_w[g]),
            .ram_addr      (ra_w[g]),
            .ram_wen       (wen_w[g]),
            .ram_ren       (ren_w[g]),
            .ram_be        (be_w[g]),
            .ram_wdata     (wd_w[g]),
            .ram_rdata     (rrd_w[g]),
            .err_drop      (err_w[g])
        );

        // RAM model: data appears exactly L cycles after ram_ren, garbage otherwise.
        always @(posedge HCLK) begin
            int          k;
            logic [31:0] o;
            k = int'(ra_w[g]);
            o = mem.exists(k) ? mem[k] : init_word(ra_w[g]);
            if (wen_w[g]) mem[k] = merge(o, wd_w[g], be_w[g]);
            pv      <= {pv[1:0], ren_w[g]};
            pipe[0] <= ren_w[g] ? o : 32'h0;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign rrd_w[g] = pv[L-1] ? pipe[L-1] : {16'hBAD0, cyc[15:0]};
    end

    task automatic chk(input string nm, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d cyc=%0d got=%h want=%h", nm, inst, cyc, act, exp);
        end
    endtask

    function automatic void add_ev(input ev_t e);
        int pos;
        pos = evq.size();
        for (int i = 0; i < evq.size(); i++) begin
            if (evq[i].inst == e.inst && evq[i].cyc == e.cyc) begin
                ev_t t;
                t = evq[i];
                t.ack |= e.ack; t.wen |= e.wen; t.ren |= e.ren; t.err |= e.err;
                if (e.bus) begin
                    t.bus = 1; t.wr = e.wr; t.addr = e.addr; t.be = e.be; t.wdata = e.wdata;
                end
                if (e.ack) t.rdata = e.rdata;
                evq[i] = t;
                return;
            end
            if (pos == evq.size() &&
                (evq[i].cyc > e.cyc || (evq[i].cyc == e.cyc && evq[i].inst > e.inst)))
                pos = i;
        end
        evq.insert(pos, e);
    endfunction

    // Lane selection straight from the HSIZE rules.
    function automatic logic [3:0] spec_be(input logic [2:0] sz, input logic [18:0] a);
        logic [3:0] be;
        int lo;
        be = 4'b0000;
        lo = int'(a[1:0]);
        if (sz == 3'd0) be[lo] = 1'b1;
        else if (sz == 3'd1) begin be[(lo/2)*2] = 1'b1; be[(lo/2)*2+1] = 1'b1; end
        else if (sz == 3'd2) be = 4'b1111;
        return be;
    endfunction

    function automatic void model_req(input int c, input bit wr, input logic [2:0] sz,
                                      input logic [18:0] a, input logic [31:0] wd);
        for (int g = 0; g < 2; g++) begin
            ev_t e;
            int L, key;
            logic [3:0] be;
            logic [16:0] w;
            logic [31:0] cur;
            L = (g == 0) ? 1 : 3;
            e = '{default: 0};
            e.inst = g;
            if (c <= busy[g]) begin
                e.cyc = c; e.err = 1;
                add_ev(e);
                continue;
            end
            be  = spec_be(sz, a);
            w   = a[18:2];
            key = g * (1 << 20) + int'(w);
            cur = ref_mem.exists(key) ? ref_mem[key] : init_word(w);
            e.bus = 1; e.wr = wr; e.addr = w; e.wdata = wd; e.cyc = c + 1;
            if (wr) begin
                e.ack = 1; e.wen = (be != 4'b0000); e.be = be; e.rdata = hold[g];
                add_ev(e);
                ref_mem[key] = merge(cur, wd, be);
                busy[g] = c + 1;
            end else begin
                e.ren = 1; e.be = (be == 4'b0000) ? 4'b1111 : be;
                add_ev(e);
                e = '{default: 0};
                e.inst = g; e.cyc = c + 2 + L; e.ack = 1; e.rdata = cur;
                add_ev(e);
                hold[g] = cur;
                busy[g] = c + 2 + L;
            end
        end
    endfunction

    always @(negedge HCLK) begin
        if (mon_en && HRESETN) begin
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                ev_t s;
                s = evq.pop_front();
                total++; bad++;
                $display("FAIL stale_event inst%0d due=%0d now=%0d", s.inst, s.cyc, cyc);
            end
            for (int i = 0; i < 2; i++) begin
                ev_t e;
                e = '{default: 0};
                if (evq.size() > 0 && evq[0].cyc == cyc && evq[0].inst == i)
                    e = evq.pop_front();
                chk("strobes{ack,wen,ren,err}", i,
                    {28'h0, ack_w[i], wen_w[i], ren_w[i], err_w[i]},
                    {28'h0, e.ack, e.wen, e.ren, e.err});
                if (e.bus) begin
                    chk("ram_addr", i, {15'h0, ra_w[i]}, {15'h0, e.addr});
                    chk("ram_be", i, {28'h0, be_w[i]}, {28'h0, e.be});
                    if (e.wr) chk("ram_wdata", i, wd_w[i], e.wdata);
                end
                if (e.ack) chk("sramahb_rdata", i, rd_w[i], e.rdata);
            end
        end
    end

    task automatic drive(input bit rq, input bit wr, input logic [2:0] sz,
                         input logic [18:0] a, input logic [31:0] wd);
        @(posedge HCLK);
        #1;
        req   = rq;
        write = rq ? wr : 1'($urandom);
        size  = rq ? sz : 3'($urandom);
        addr  = rq ? a : 19'($urandom);
        wdata = rq ? wd : $urandom;
        if (rq) model_req(cyc, wr, sz, a, wd);
    endtask

    task automatic idle1();
        drive(0, 0, 3'd0, 19'h0, 32'h0);
    endtask

    task automatic wait_idle();
        int mx;
        int guard;
        mx = (busy[0] > busy[1]) ? busy[0] : busy[1];
        guard = 0;
        while (cyc + 1 <= mx && guard < 20) begin
            idle1();
            guard++;
        end
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_ack"}, i, {31'h0, ack_w[i]}, 32'h0);
            chk({tag, "_wen"}, i, {31'h0, wen_w[i]}, 32'h0);
            chk({tag, "_ren"}, i, {31'h0, ren_w[i]}, 32'h0);
            chk({tag, "_err"}, i, {31'h0, err_w[i]}, 32'h0);
            chk({tag, "_addr"}, i, {15'h0, ra_w[i]}, 32'h0);
            chk({tag, "_be"}, i, {28'h0, be_w[i]}, 32'h0);
            chk({tag, "_wdata"}, i, wd_w[i], 32'h0);
            chk({tag, "_rdata"}, i, rd_w[i], 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        HRESETN = 1'b0;
        req = 0; write = 0; size = 3'd0; addr = 19'h0; wdata = 32'h0;
        busy[0] = -1; busy[1] = -1;
        hold[0] = 32'h0; hold[1] = 32'h0;
        repeat (2) @(posedge HCLK);
        #1;
        check_zero("reset");
        HRESETN = 1'b1;
        mon_en  = 1'b1;
        idle1();

        // Word write, then every byte and half-word lane pattern.
        drive(1, 1, 3'd2, 19'h00010, 32'hDEADBEEF); wait_idle(); idle1();
        drive(1, 1, 3'd0, 19'h00003, 32'h11223344); wait_idle();
        drive(1, 1, 3'd0, 19'h00002, 32'h55667788); wait_idle();
        drive(1, 1, 3'd0, 19'h00001, 32'h99AABBCC); wait_idle();
        drive(1, 1, 3'd0, 19'h00000, 32'hDDEEFF00); wait_idle();
        drive(1, 1, 3'd1, 19'h00002, 32'hCAFEF00D); wait_idle();
        drive(1, 1, 3'd1, 19'h00000, 32'h0BADC0DE); wait_idle();
        drive(1, 1, 3'd1, 19'h00003, 32'hA5A5A5A5); wait_idle();

        // Read back a known word under both latencies; held through the next write.
        drive(1, 1, 3'd2, 19'h00040, 32'h12345678); wait_idle();
        drive(1, 0, 3'd2, 19'h00040, 32'h0);        wait_idle();
        drive(1, 1, 3'd2, 19'h00044, 32'h0F0F0F0F); wait_idle();

        // Back-to-back burst: each req one cycle after the previous ack.
        for (int b = 0; b < 4; b++) begin
            drive(1, 1, 3'd2, 19'(32'h80 + 4 * b), 32'hB0000000 + b);
            idle1();
        end
        wait_idle();

        // Request during READ is dropped; unsupported-size write acks without a strobe.
        drive(1, 0, 3'd2, 19'h00040, 32'h0);
        idle1();
        drive(1, 1, 3'd2, 19'h00048, 32'hFFFFFFFF);
        wait_idle();
        drive(1, 1, 3'd3, 19'h0004C, 32'h77777777); wait_idle();
        drive(1, 0, 3'd5, 19'h0004C, 32'h0);        wait_idle();

        // Reset in the second READ cycle: everything clears, no late ack.
        drive(1, 0, 3'd2, 19'h00010, 32'h0);
        idle1();
        @(posedge HCLK);
        #3;
        HRESETN = 1'b0;
        #1;
        check_zero("midreset");
        evq.delete();
        busy[0] = -1; busy[1] = -1;
        hold[0] = 32'h0; hold[1] = 32'h0;
        repeat (2) @(posedge HCLK);
        #1;
        HRESETN = 1'b1;
        repeat (6) idle1();
        drive(1, 0, 3'd2, 19'h00040, 32'h0); wait_idle();

        // Random traffic, including requests that land while busy.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 2) == 0)
                drive(1, 1'($urandom), 3'($urandom_range(0, 5)),
                      ($urandom_range(0, 1) != 0 ? 19'h7FFC0 : 19'h0) + 19'($urandom_range(0, 63)),
                      $urandom);
            else
                idle1();
        end
        wait_idle();
        repeat (3) idle1();
        chk("events_outstanding", 0, 32'(evq.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
